// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared defaults and a parity helper for the serial LFSR.
// The helper is also usable as a reference model for the next input bit.
package lfsr_pkg;

  localparam int       LFSR_DEF_WIDTH = 4;
  localparam logic [3:0] LFSR_DEF_TAPS = 4'b0011;

  // Parity of the tapped state bits (zero-extended to 32 bits by callers).
  function automatic logic lfsr_parity(input logic [31:0] state, input logic [31:0] taps);
    return ^(state & taps);
  endfunction

endpackage

// File: rtl/lfsr_feedback.sv
// lfsr_feedback: combinational selection of the bit shifted into the LFSR MSB.
// Load mode passes si through; run mode uses the XOR of the tapped state bits.
// Optional macro LFSR_LOCKUP_RECOVER_EN forces a 1 into the MSB when the
// register is all-zero in run mode, escaping the lock-up fixed point.
module lfsr_feedback
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS)
) (
  input  logic [WIDTH-1:0] state,
  input  logic             en,
  input  logic             si,
  output logic             in_bit
);

  logic [WIDTH-1:0] tapped;
  logic             parity;

  // Mask each state bit with its tap; a zero mask yields constant-zero feedback.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
    assign tapped[gi] = state[gi] & TAPS[gi];
  end

  assign parity = ^tapped;

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic lockup;

  // All-zero state while running would otherwise be a fixed point.
  assign lockup = en && (state == '0);

  // Pick the incoming bit: serial data, forced 1 on lock-up, or feedback.
  always_comb begin
    in_bit = si;
    if (lockup)  in_bit = 1'b1;
    else if (en) in_bit = parity;
  end
`else
  // Pick the incoming bit: serial data in load mode, feedback in run mode.
  always_comb begin
    in_bit = si;
    if (en) in_bit = parity;
  end
`endif

endmodule

// File: rtl/lfsr_serial.sv
// lfsr_serial: serial-in/serial-out Fibonacci LFSR.
// en=0 shifts si into the MSB (seeding); en=1 shifts tapped XOR feedback.
// Right-shifts on every rising edge; q is the register LSB.
// Optional macro LFSR_LOCKUP_RECOVER_EN (handled in lfsr_feedback).
module lfsr_serial
  import lfsr_pkg::*;
#(
  parameter int               WIDTH   = LFSR_DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS    = WIDTH'(LFSR_DEF_TAPS),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic si,
  output logic q
);

  logic [WIDTH-1:0] state_reg;
  logic             in_bit;

  lfsr_feedback #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_feedback (
    .state  (state_reg),
    .en     (en),
    .si     (si),
    .in_bit (in_bit)
  );

  // State register: asynchronous reset to RST_VAL, otherwise right shift each edge.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= RST_VAL;
    end else begin
      state_reg <= {in_bit, state_reg[WIDTH-1:1]};
    end
  end

  assign q = state_reg[0];

endmodule

// File: tb/tb_lfsr_serial.sv
// tb_lfsr_serial: directed checks of lfsr_serial with default parameters.
module tb_lfsr_serial;
  import lfsr_pkg::*;

  logic clk;
  logic arst_n;
  logic en;
  logic si;
  logic q;

  int checks = 0;
  int errors = 0;

  lfsr_serial #(
    .WIDTH   (4),
    .TAPS    (4'b0011),
    .RST_VAL (4'b0000)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .en     (en),
    .si     (si),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs away from the edge, take one rising edge, settle 1ns after it.
  task automatic tick(input logic e, input logic s);
    en = e;
    si = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model_next(input logic [3:0] st, input logic e, input logic s);
    logic b;
    b = e ? lfsr_parity(32'(st), 32'(4'b0011)) : s;
`ifdef LFSR_LOCKUP_RECOVER_EN
    if (e && st == 4'b0000) b = 1'b1;
`endif
    return {b, st[3:1]};
  endfunction

  initial begin
    logic [3:0] m;
    logic [3:0] seed;
    logic [15:0] seen;
    logic [3:0] load_exp [4];
    logic [3:0] run_exp [4];
    logic       run_q [4];
    logic       hist [20];

    load_exp = '{4'b1000, 4'b0100, 4'b1010, 4'b0101};
    run_exp  = '{4'b1010, 4'b1101, 4'b1110, 4'b1111};
    run_q    = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset held with clock running
    arst_n = 1'b0;
    en = 1'b0;
    si = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dut.state_reg), 32'h0);
    check("reset_q", 32'(q), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    // Load 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
      check($sformatf("load_state_%0d", i), 32'(dut.state_reg), 32'(load_exp[i]));
      $display("load edge %0d: si=%0b state=%b q=%0b", i, si, dut.state_reg, q);
    end
    check("load_q", 32'(q), 32'h1);

    // Load all ones
    repeat (4) tick(1'b0, 1'b1);
    check("load_ones", 32'(dut.state_reg), 32'hF);
    check("load_ones_q", 32'(q), 32'h1);

    // Reload 0101 for the run sequence
    for (int i = 0; i < 4; i++) tick(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0);
    check("reload", 32'(dut.state_reg), 32'h5);

    // Run from 0101
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
      check($sformatf("run_state_%0d", i), 32'(dut.state_reg), 32'(run_exp[i]));
      check($sformatf("run_q_%0d", i), 32'(q), 32'(run_q[i]));
      $display("run edge %0d: state=%b q=%0b", i, dut.state_reg, q);
    end

    // Period: from seed 1111, 15 edges visit all non-zero values
    seed = 4'b1111;
    m = seed;
    seen = '0;
    for (int i = 1; i <= 15; i++) begin
      tick(1'b1, 1'b0);
      m = model_next(m, 1'b1, 1'b0);
      seen[dut.state_reg] = 1'b1;
      check($sformatf("period_state_%0d", i), 32'(dut.state_reg), 32'(m));
      if (i < 15) check($sformatf("period_norepeat_%0d", i), 32'(dut.state_reg == seed), 32'h0);
    end
    check("period_return", 32'(dut.state_reg), 32'(seed));
    check("period_coverage", 32'(seen), 32'hFFFE);

    // Async reset mid-run, observed before the next edge
    tick(1'b1, 1'b0);
    check("prereset_nonzero", 32'(dut.state_reg != 4'b0000), 32'h1);
    #2;
    arst_n = 1'b0;
    #1;
    check("async_reset_state", 32'(dut.state_reg), 32'h0);
    check("async_reset_q", 32'(q), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    en = 1'b0;
    si = 1'b1;

    // 20 load edges, alternating si starting at 1; q lags si by WIDTH-1 edges after each edge
    for (int k = 0; k < 20; k++) begin
      hist[k] = (k % 2 == 0) ? 1'b1 : 1'b0;
      tick(1'b0, hist[k]);
      check($sformatf("lag_q_%0d", k), 32'(q), (k >= 3) ? 32'(hist[k-3]) : 32'h0);
    end
    check("loaded_state", 32'(dut.state_reg), 32'h5);

    // Mode switch continues from the loaded state
    m = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      m = model_next(m, 1'b1, 1'b0);
      check($sformatf("switch_state_%0d", i), 32'(dut.state_reg), 32'(m));
    end

    // Lock-up from the all-zero state in run mode
    #2;
    arst_n = 1'b0;
    en = 1'b1;
    #1;
    @(negedge clk);
    arst_n = 1'b1;
    m = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0);
      m = model_next(m, 1'b1, 1'b0);
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (i == 0) check("lockup_first", 32'(dut.state_reg), 32'h8);
`else
      check($sformatf("lockup_zero_%0d", i), 32'(dut.state_reg), 32'h0);
`endif
      check($sformatf("lockup_state_%0d", i), 32'(dut.state_reg), 32'(m));
      check($sformatf("lockup_q_%0d", i), 32'(q), 32'(m[0]));
      $display("lockup edge %0d: state=%b q=%0b", i, dut.state_reg, q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
